// File: rtl/wishbone_byte_lane_ram.sv
// Wishbone single-port word RAM with byte-lane writes, registered read address
// and an optional hardware fill sequence after reset.
module wishbone_byte_lane_ram #(
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    ADDR_WIDTH      = 13,
   parameter int                    MEM_WORDS       = 2048,
   parameter int                    CLEAR_ON_RESET  = 0,
   parameter logic [DATA_WIDTH-1:0] FILL_VALUE      = '0,
   parameter string                 MEMORY_FILENAME = ""
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cyc_i,
   input  logic                    stb_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] sel_i,
   input  logic [ADDR_WIDTH-1:0]   adr_i,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic                    ack_o,
   output logic                    err_o,
   output logic                    init_done_o
);

   // state | meaning
   // CLEAR | filling words 0..MEM_WORDS-1 with FILL_VALUE, requests held off
   // IDLE  | ready, samples cyc_i & stb_i
   // RESP  | ack_o or err_o high for the accepted request

   localparam int NB  = DATA_WIDTH / 8;
   localparam int LSB = $clog2(NB);
   localparam int IW  = ADDR_WIDTH - LSB;
   localparam int MAW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [IW:0]    WORDS_C = (IW+1)'(MEM_WORDS);
   localparam logic [MAW-1:0] LAST_C  = MAW'(MEM_WORDS - 1);

   typedef enum logic [1:0] {CLEAR, IDLE, RESP} state_t;

   state_t          state_q;
   logic [MAW-1:0]  clr_cnt_q;
   logic [MAW-1:0]  raddr_q;
   logic            ack_q;
   logic            err_q;
   logic            rd_q;
   logic            init_done_q;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   logic [IW-1:0]         word_idx;
   logic                  in_range;
   logic                  req;
   logic                  mem_we;
   logic [MAW-1:0]        mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [NB-1:0]         mem_be;

   assign word_idx = adr_i[ADDR_WIDTH-1:LSB];
   assign in_range = {1'b0, word_idx} < WORDS_C;
   assign req      = cyc_i & stb_i;

   generate
      if (LSB > 0) begin : g_unused_lsb
         logic unused_adr_lsb;
         assign unused_adr_lsb = ^adr_i[LSB-1:0];
      end
   endgenerate

   // Clear and bus writes share the one write port; clear always owns it in CLEAR.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = word_idx[MAW-1:0];
      mem_wdata = dat_i;
      mem_be    = sel_i;
      if (!rst_i && state_q == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt_q;
         mem_wdata = FILL_VALUE;
         mem_be    = '1;
      end else if (!rst_i && state_q == IDLE && req && we_i && in_range) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int k = 0; k < NB; k++) begin
            if (mem_be[k]) mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         clr_cnt_q   <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         rd_q        <= 1'b0;
         init_done_q <= (CLEAR_ON_RESET == 0);
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         rd_q  <= 1'b0;
         case (state_q)
            CLEAR: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               if (clr_cnt_q == LAST_C) begin
                  clr_cnt_q   <= '0;
                  state_q     <= IDLE;
                  init_done_q <= 1'b1;
               end
            end
            IDLE: begin
               if (req) begin
                  state_q <= RESP;
                  ack_q   <= in_range;
                  err_q   <= ~in_range;
                  rd_q    <= in_range & ~we_i;
                  raddr_q <= word_idx[MAW-1:0];
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dat_o       = rd_q ? mem[raddr_q] : '0;
   assign ack_o       = ack_q;
   assign err_o       = err_q;
   assign init_done_o = init_done_q;

   initial begin
      if (CLEAR_ON_RESET != 0 && MEMORY_FILENAME != "")
         $display("wishbone_byte_lane_ram: configuration error, CLEAR_ON_RESET=1 with MEMORY_FILENAME set");
   end

endmodule

// File: tb/tb_wishbone_byte_lane_ram.sv
// Bench for wishbone_byte_lane_ram: one plain instance (2048 words, 14-bit byte
// address so out-of-range words are reachable) and one clear-on-reset instance.
module tb_wishbone_byte_lane_ram;

   typedef struct {
      logic        ack;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = '0;
   logic [13:0] adr = '0;
   logic [31:0] dat = '0, dat_o;
   logic        ack, err, done;

   logic        c_rst = 1'b1, c_cyc = 1'b0, c_stb = 1'b0, c_we = 1'b0;
   logic [3:0]  c_sel = '0;
   logic [12:0] c_adr = '0;
   logic [31:0] c_dat = '0, c_dat_o;
   logic        c_ack, c_err, c_done;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   logic [31:0] model  [2048];
   logic [31:0] cmodel [16];

   always #5 clk = ~clk;

   wishbone_byte_lane_ram #(
      .DATA_WIDTH(32), .ADDR_WIDTH(14), .MEM_WORDS(2048), .CLEAR_ON_RESET(0)
   ) u_dut (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel),
      .adr_i(adr), .dat_i(dat), .dat_o(dat_o), .ack_o(ack), .err_o(err),
      .init_done_o(done)
   );

   wishbone_byte_lane_ram #(
      .DATA_WIDTH(32), .ADDR_WIDTH(13), .MEM_WORDS(16), .CLEAR_ON_RESET(1),
      .FILL_VALUE(32'hDEADBEEF)
   ) u_clr (
      .clk_i(clk), .rst_i(c_rst), .cyc_i(c_cyc), .stb_i(c_stb), .we_i(c_we), .sel_i(c_sel),
      .adr_i(c_adr), .dat_i(c_dat), .dat_o(c_dat_o), .ack_o(c_ack), .err_o(c_err),
      .init_done_o(c_done)
   );

   // Drives one access, pushes the model's expectation, returns with the response sampled.
   task automatic issue(input bit c, input logic w, input logic [3:0] s,
                        input logic [13:0] a, input logic [31:0] d, output int lat);
      exp_t e;
      int   widx;
      bit   inr;
      @(posedge clk);
      @(negedge clk);
      widx   = c ? int'(a[12:2]) : int'(a[13:2]);
      inr    = c ? (widx < 16) : (widx < 2048);
      e.ack  = inr;
      e.err  = !inr;
      e.data = (inr && !w) ? (c ? cmodel[widx] : model[widx]) : 32'h0;
      if (inr && w) begin
         for (int k = 0; k < 4; k++) begin
            if (s[k]) begin
               if (c) cmodel[widx][8*k +: 8] = d[8*k +: 8];
               else   model[widx][8*k +: 8]  = d[8*k +: 8];
            end
         end
      end
      sb.push_back(e);
      if (c) begin
         c_cyc = 1'b1; c_stb = 1'b1; c_we = w; c_sel = s; c_adr = a[12:0]; c_dat = d;
      end else begin
         cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
      end
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!(c ? (c_ack | c_err) : (ack | err)) && lat < 8);
      if (c) begin c_cyc = 1'b0; c_stb = 1'b0; end
      else   begin cyc = 1'b0;   stb = 1'b0;   end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (ack !== 1'b0 || err !== 1'b0 || dat_o !== 32'h0 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_plain: ack=%b err=%b dat_o=%h done=%b, want 0 0 00000000 1", ack, err, dat_o, done);
      end
      n_checks++;
      if (c_ack !== 1'b0 || c_err !== 1'b0 || c_dat_o !== 32'h0 || c_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_clear: ack=%b err=%b dat_o=%h done=%b, want 0 0 00000000 0", c_ack, c_err, c_dat_o, c_done);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL init_done_after_reset: done=%b, want 1", done);
      end
   endtask

   task automatic test_write_read();
      exp_t e;
      int   lat;
      issue(0, 1'b1, 4'hF, 14'h0010, 32'h11223344, lat);
      e = sb.pop_front();
      n_checks++;
      if (ack !== e.ack || err !== e.err || dat_o !== e.data || lat !== 1) begin
         n_fail++;
         $display("FAIL write_full: ack=%b err=%b dat_o=%h lat=%0d, want %b %b %h lat=1", ack, err, dat_o, lat, e.ack, e.err, e.data);
      end
      issue(0, 1'b0, 4'hF, 14'h0010, 32'h0, lat);
      e = sb.pop_front();
      n_checks++;
      if (ack !== e.ack || err !== e.err || dat_o !== 32'h11223344 || lat !== 1) begin
         n_fail++;
         $display("FAIL read_full: ack=%b err=%b dat_o=%h lat=%0d, want 1 0 11223344 lat=1", ack, err, dat_o, lat);
      end
   endtask

   task automatic test_byte_lanes();
      exp_t e;
      int   lat;
      issue(0, 1'b1, 4'b0101, 14'h0010, 32'hAABBCCDD, lat);
      e = sb.pop_front();
      n_checks++;
      if (ack !== e.ack || err !== e.err || dat_o !== e.data || lat !== 1) begin
         n_fail++;
         $display("FAIL write_sel0101: ack=%b err=%b dat_o=%h lat=%0d, want %b %b %h lat=1", ack, err, dat_o, lat, e.ack, e.err, e.data);
      end
      issue(0, 1'b0, 4'hF, 14'h0010, 32'h0, lat);
      e = sb.pop_front();
      n_checks++;
      if (ack !== 1'b1 || dat_o !== e.data || dat_o !== 32'h11BB33DD) begin
         n_fail++;
         $display("FAIL read_sel0101: ack=%b dat_o=%h, want 1 11BB33DD (model %h)", ack, dat_o, e.data);
      end
      issue(0, 1'b1, 4'b0000, 14'h0010, 32'hFFFFFFFF, lat);
      e = sb.pop_front();
      n_checks++;
      if (ack !== 1'b1 || err !== 1'b0 || dat_o !== 32'h0 || lat !== 1) begin
         n_fail++;
         $display("FAIL write_sel0000: ack=%b err=%b dat_o=%h lat=%0d, want 1 0 00000000 lat=1", ack, err, dat_o, lat);
      end
      issue(0, 1'b0, 4'b0000, 14'h0010, 32'h0, lat);
      e = sb.pop_front();
      n_checks++;
      if (ack !== 1'b1 || dat_o !== e.data || dat_o !== 32'h11BB33DD) begin
         n_fail++;
         $display("FAIL read_after_sel0000: ack=%b dat_o=%h, want 1 11BB33DD", ack, dat_o);
      end
   endtask

   task automatic test_out_of_range();
      exp_t e;
      int   lat;
      logic        tw [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [13:0] ta [7] = '{14'h0000, 14'h1FFC, 14'h2000, 14'h2000, 14'h0000, 14'h1FFC, 14'h3FFC};
      logic [31:0] td [7] = '{32'hCAFEF00D, 32'h5A5A5A5A, 32'h0, 32'h01020304, 32'h0, 32'h0, 32'h0};
      for (int i = 0; i < 7; i++) begin
         issue(0, tw[i], 4'hF, ta[i], td[i], lat);
         e = sb.pop_front();
         n_checks++;
         if (ack !== e.ack || err !== e.err || dat_o !== e.data || lat !== 1) begin
            n_fail++;
            $display("FAIL range[%0d] adr=%h: ack=%b err=%b dat_o=%h lat=%0d, want %b %b %h lat=1", i, ta[i], ack, err, dat_o, lat, e.ack, e.err, e.data);
         end
         if (i == 2) begin
            @(posedge clk); #1;
            n_checks++;
            if (err !== 1'b0 || ack !== 1'b0) begin
               n_fail++;
               $display("FAIL err_pulse_width: err=%b ack=%b one cycle later, want 0 0", err, ack);
            end
         end
      end
      n_checks++;
      if (model[0] !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL model_word0: model=%h, want CAFEF00D", model[0]);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   lat;
      issue(0, 1'b1, 4'hF, 14'h0004, 32'h0BADBEEF, lat);
      void'(sb.pop_front());
      sb.push_back('{ack: 1'b1, err: 1'b0, data: model[0]});
      sb.push_back('{ack: 1'b0, err: 1'b0, data: 32'h0});
      sb.push_back('{ack: 1'b1, err: 1'b0, data: model[1]});
      @(posedge clk);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 14'h0000;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if (ack !== e.ack || err !== e.err || dat_o !== e.data) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: ack=%b err=%b dat_o=%h, want %b %b %h", k, ack, err, dat_o, e.ack, e.err, e.data);
         end
         if (k == 0) adr = 14'h0004;
      end
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic test_reset_in_resp();
      exp_t e;
      int   lat;
      issue(0, 1'b0, 4'hF, 14'h0010, 32'h0, lat);
      e = sb.pop_front();
      n_checks++;
      if (ack !== 1'b1 || dat_o !== e.data) begin
         n_fail++;
         $display("FAIL read_before_reset: ack=%b dat_o=%h, want 1 %h", ack, dat_o, e.data);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (ack !== 1'b0 || err !== 1'b0 || dat_o !== 32'h0 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_resp: ack=%b err=%b dat_o=%h done=%b, want 0 0 00000000 1", ack, err, dat_o, done);
      end
      rst = 1'b0;
      issue(0, 1'b0, 4'hF, 14'h0010, 32'h0, lat);
      e = sb.pop_front();
      n_checks++;
      if (ack !== 1'b1 || dat_o !== e.data || dat_o !== 32'h11BB33DD || lat !== 1) begin
         n_fail++;
         $display("FAIL survive_reset: ack=%b dat_o=%h lat=%0d, want 1 11BB33DD lat=1", ack, dat_o, lat);
      end
   endtask

   task automatic test_clear();
      exp_t e;
      int   first_done = 0;
      int   ack_cyc    = 0;
      bool_early: begin end
      sb.push_back('{ack: 1'b1, err: 1'b0, data: 32'hDEADBEEF});
      c_cyc = 1'b1; c_stb = 1'b1; c_we = 1'b0; c_sel = 4'hF; c_adr = 13'h0;
      @(posedge clk); #1;
      c_rst = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (c_done && first_done == 0) first_done = k;
         if (c_ack || c_err) begin
            ack_cyc = k;
            break;
         end
      end
      c_cyc = 1'b0; c_stb = 1'b0;
      n_checks++;
      if (first_done !== 16) begin
         n_fail++;
         $display("FAIL clear_done_cycle: init_done rose at cycle %0d, want 16", first_done);
      end
      e = sb.pop_front();
      n_checks++;
      if (ack_cyc !== 17 || c_ack !== e.ack || c_err !== e.err || c_dat_o !== e.data) begin
         n_fail++;
         $display("FAIL clear_first_ack: cycle=%0d ack=%b err=%b dat_o=%h, want 17 1 0 %h", ack_cyc, c_ack, c_err, c_dat_o, e.data);
      end
      for (int i = 0; i < 16; i++) cmodel[i] = 32'hDEADBEEF;
   endtask

   task automatic test_clear_abort();
      exp_t e;
      int   lat;
      int   first_done = 0;
      issue(1, 1'b1, 4'hF, 14'h000C, 32'h12345678, lat);
      void'(sb.pop_front());
      issue(1, 1'b1, 4'b0011, 14'h0030, 32'h0F0F0F0F, lat);
      void'(sb.pop_front());
      issue(1, 1'b0, 4'hF, 14'h000C, 32'h0, lat);
      e = sb.pop_front();
      n_checks++;
      if (c_ack !== 1'b1 || c_dat_o !== e.data || c_dat_o !== 32'h12345678) begin
         n_fail++;
         $display("FAIL clr_dut_write: ack=%b dat_o=%h, want 1 12345678", c_ack, c_dat_o);
      end
      @(negedge clk);
      c_rst = 1'b1;
      @(posedge clk); #1;
      c_rst = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      c_rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (c_done !== 1'b0 || c_ack !== 1'b0 || c_err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_clear_reset: done=%b ack=%b err=%b, want 0 0 0", c_done, c_ack, c_err);
      end
      c_rst = 1'b0;
      for (int k = 1; k <= 40 && first_done == 0; k++) begin
         @(posedge clk); #1;
         if (c_done) first_done = k;
      end
      n_checks++;
      if (first_done !== 16) begin
         n_fail++;
         $display("FAIL restart_done_cycle: init_done rose at cycle %0d, want 16", first_done);
      end
      for (int i = 0; i < 16; i++) cmodel[i] = 32'hDEADBEEF;
      for (int i = 0; i < 16; i++) begin
         issue(1, 1'b0, 4'hF, 14'(i * 4), 32'h0, lat);
         e = sb.pop_front();
         n_checks++;
         if (c_ack !== e.ack || c_err !== e.err || c_dat_o !== e.data || lat !== 1) begin
            n_fail++;
            $display("FAIL refill_word[%0d]: ack=%b err=%b dat_o=%h lat=%0d, want %b %b %h lat=1", i, c_ack, c_err, c_dat_o, lat, e.ack, e.err, e.data);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) model[i] = 32'h0;
      for (int i = 0; i < 16; i++) cmodel[i] = 32'h0;
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_out_of_range();
      test_back_to_back();
      test_reset_in_resp();
      test_clear();
      test_clear_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
